// File: rtl/trace_trig_seq.sv
// Multi-step trace trigger sequencer: walks up to pSTEPS rule matches with an inter-step timeout.
// Define TRACE_TRIG_SEQ_AUTOREARM_EN to add I_holdoff and automatic rearm from DONE.
`timescale 1ns/1ps
module trace_trig_seq #(
  parameter int pMATCH_RULES = 8,
  parameter int pSTEPS       = 4,
  parameter int pTIMER_WIDTH = 16
) (
  input  logic                    trace_clk,
  input  logic                    reset_n,
  input  logic [pMATCH_RULES-1:0] I_match,
  input  logic                    I_synchronized,
  input  logic                    I_arm,
  input  logic                    I_disarm,
  input  logic [1:0]              I_num_steps,
  input  logic [pSTEPS*3-1:0]     I_step_rules,
  input  logic [pTIMER_WIDTH-1:0] I_timeout,
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
  input  logic [pTIMER_WIDTH-1:0] I_holdoff,
`endif
  output logic                    O_trigger,
  output logic [1:0]              O_state,
  output logic [1:0]              O_step,
  output logic [7:0]              O_timeouts
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SEQ   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [pTIMER_WIDTH-1:0] TIMER_ONE = pTIMER_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [1:0]              step_q, step_d;
  logic [pTIMER_WIDTH-1:0] timer_q, timer_d;
  logic [7:0]              timeouts_q, timeouts_d;
  logic                    trigger_q, trigger_d;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
  logic [pTIMER_WIDTH-1:0] hold_q, hold_d;
`endif

  logic [2:0] rule_sel;
  logic       rule_valid;
  logic       rule_hit;
  logic       step_sat;
  logic       expire;

  // Rule index for the awaited step; a step beyond pSTEPS has no rule and never matches.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rule_sel   = '0;
    rule_valid = 1'b0;
    for (int k = 0; k < pSTEPS; k++) begin
      if (int'(step_q) == k) begin
        rule_sel   = I_step_rules[3*k +: 3];
        rule_valid = 1'b1;
      end
    end
  end

  // Indices at or above pMATCH_RULES fall through the loop and stay unmatched.
  always_comb begin
    rule_hit = 1'b0;
    for (int r = 0; r < pMATCH_RULES; r++) begin
      if (int'(rule_sel) == r) rule_hit = I_match[r];
    end
  end

  assign step_sat = rule_valid & rule_hit & I_synchronized;
  assign expire   = (I_timeout != '0) && (timer_q == (I_timeout - TIMER_ONE));

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    timer_d    = timer_q;
    timeouts_d = timeouts_q;
    trigger_d  = 1'b0;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
    hold_d     = hold_q;
`endif

    if (I_disarm) begin
      state_d = ST_IDLE;
      step_d  = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (I_arm) begin
            state_d = ST_ARMED;
            step_d  = '0;
          end
        end

        ST_ARMED: begin
          if (step_sat) begin
            timer_d = '0;
            if (I_num_steps == 2'd0) begin
              state_d   = ST_DONE;
              step_d    = '0;
              trigger_d = 1'b1;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
              hold_d    = '0;
`endif
            end else begin
              state_d = ST_SEQ;
              step_d  = 2'd1;
            end
          end
        end

        // Loss of sync beats both a match and expiry; a match beats expiry.
        ST_SEQ: begin
          if (!I_synchronized) begin
            state_d = ST_ARMED;
            step_d  = '0;
            timer_d = '0;
          end else if (step_sat) begin
            timer_d = '0;
            if (step_q == I_num_steps) begin
              state_d   = ST_DONE;
              trigger_d = 1'b1;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
              hold_d    = '0;
`endif
            end else begin
              step_d = step_q + 2'd1;
            end
          end else if (expire) begin
            state_d = ST_ARMED;
            step_d  = '0;
            timer_d = '0;
            if (timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end

        ST_DONE: begin
          if (I_arm) begin
            state_d = ST_ARMED;
            step_d  = '0;
          end
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
          else if (hold_q == I_holdoff) begin
            state_d = ST_ARMED;
            step_d  = '0;
          end else begin
            hold_d = hold_q + TIMER_ONE;
          end
`endif
        end

        default: begin
          state_d = ST_IDLE;
          step_d  = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      timer_q    <= '0;
      timeouts_q <= '0;
      trigger_q  <= 1'b0;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
      hold_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      step_q     <= step_d;
      timer_q    <= timer_d;
      timeouts_q <= timeouts_d;
      trigger_q  <= trigger_d;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign O_trigger  = trigger_q;
  assign O_state    = state_q;
  assign O_step     = step_q;
  assign O_timeouts = timeouts_q;

endmodule

// File: tb/tb_trace_trig_seq.sv
// Directed bench for trace_trig_seq: expected triggers queue in a scoreboard that a
// negedge monitor drains; state/step/timeout snapshots are checked inline.
`timescale 1ns/1ps
module tb_trace_trig_seq;

  typedef struct packed {
    logic [1:0] state;
    logic [1:0] step;
    logic [7:0] timeouts;
  } trig_t;

  logic        trace_clk = 1'b0;
  logic        reset_n;
  logic [7:0]  I_match;
  logic        I_synchronized;
  logic        I_arm;
  logic        I_disarm;
  logic [1:0]  I_num_steps;
  logic [11:0] I_step_rules;
  logic [15:0] I_timeout;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
  logic [15:0] I_holdoff;
`endif
  logic        O_trigger;
  logic [1:0]  O_state;
  logic [1:0]  O_step;
  logic [7:0]  O_timeouts;

  int    checks = 0;
  int    errors = 0;
  trig_t exp_q[$];

  trace_trig_seq dut (
    .trace_clk      (trace_clk),
    .reset_n        (reset_n),
    .I_match        (I_match),
    .I_synchronized (I_synchronized),
    .I_arm          (I_arm),
    .I_disarm       (I_disarm),
    .I_num_steps    (I_num_steps),
    .I_step_rules   (I_step_rules),
    .I_timeout      (I_timeout),
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
    .I_holdoff      (I_holdoff),
`endif
    .O_trigger      (O_trigger),
    .O_state        (O_state),
    .O_step         (O_step),
    .O_timeouts     (O_timeouts)
  );

  always #5 trace_clk = ~trace_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_st(input string name, input int st, input int stp, input int to);
    check({name, ".state"},    int'(O_state),    st);
    check({name, ".step"},     int'(O_step),     stp);
    check({name, ".timeouts"}, int'(O_timeouts), to);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge trace_clk);
      #1;
    end
  endtask

  task automatic expect_trig(input logic [1:0] st, input logic [1:0] stp, input logic [7:0] to);
    trig_t t;
    t.state    = st;
    t.step     = stp;
    t.timeouts = to;
    exp_q.push_back(t);
  endtask

  // Monitor: every trigger pulse must match the oldest queued expectation.
  initial begin
    trig_t e;
    forever begin
      @(negedge trace_clk);
      if (O_trigger === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_trigger: got state=%0d step=%0d timeouts=%0d expected no trigger",
                   O_state, O_step, O_timeouts);
        end else begin
          e = exp_q.pop_front();
          if ({O_state, O_step, O_timeouts} !== e) begin
            errors++;
            $display("FAIL trigger_ctx: got state=%0d step=%0d timeouts=%0d expected state=%0d step=%0d timeouts=%0d",
                     O_state, O_step, O_timeouts, e.state, e.step, e.timeouts);
          end
        end
      end
    end
  end

  initial begin
    bit held;
    reset_n        = 1'b0;
    I_match        = '0;
    I_synchronized = 1'b1;
    I_arm          = 1'b0;
    I_disarm       = 1'b0;
    I_num_steps    = '0;
    I_step_rules   = '0;
    I_timeout      = '0;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
    I_holdoff      = 16'hFFFF;
`endif
    #12;
    check_st("in_reset", 0, 0, 0);
    check("in_reset.trigger", int'(O_trigger), 0);
    @(negedge trace_clk);
    reset_n = 1'b1;
    cyc(1);
    check_st("post_reset", 0, 0, 0);

    // Single step, rule 3.
    I_step_rules = 12'h003;
    I_arm = 1'b1; cyc(1); I_arm = 1'b0;
    check_st("t1_armed", 1, 0, 0);
    I_match = 8'h04; cyc(1);
    check_st("t1_wrong_rule", 1, 0, 0);
    I_match = 8'h08; I_synchronized = 1'b0; cyc(1);
    check_st("t1_unsynced", 1, 0, 0);
    I_synchronized = 1'b1;
    expect_trig(2'd3, 2'd0, 8'd0);
    cyc(1); I_match = '0;
    check_st("t1_done", 3, 0, 0);
    check("t1_trigger_high", int'(O_trigger), 1);
    cyc(1);
    check("t1_trigger_low", int'(O_trigger), 0);
    check_st("t1_done_hold", 3, 0, 0);

    // Three steps, rules 1,2,5, timeout 10.
    I_step_rules = 12'h151; I_num_steps = 2'd2; I_timeout = 16'd10;
    I_arm = 1'b1; cyc(1); I_arm = 1'b0;
    check_st("t2_rearm", 1, 0, 0);
    I_match = 8'h02; cyc(1); I_match = '0;
    check_st("t2_step1", 2, 1, 0);
    I_arm = 1'b1; cyc(1); I_arm = 1'b0;
    check_st("t2_arm_ignored", 2, 1, 0);
    I_match = 8'h02; cyc(1); I_match = '0;
    check_st("t2_stale_rule", 2, 1, 0);
    I_match = 8'h04; cyc(1); I_match = '0;
    check_st("t2_step2", 2, 2, 0);
    cyc(2);
    expect_trig(2'd3, 2'd2, 8'd0);
    I_match = 8'h20; cyc(1); I_match = '0;
    check_st("t2_done", 3, 2, 0);

    // Timeout 4, two steps (rules 1,2).
    I_step_rules = 12'h011; I_num_steps = 2'd1; I_timeout = 16'd4;
    I_arm = 1'b1; cyc(1); I_arm = 1'b0;
    I_match = 8'h02; cyc(1); I_match = '0;
    check_st("t3_seq", 2, 1, 0);
    cyc(3);
    check_st("t3_before_expiry", 2, 1, 0);
    cyc(1);
    check_st("t3_expired", 1, 0, 1);

    // Match coincides with expiry: match wins.
    I_match = 8'h02; cyc(1); I_match = '0;
    cyc(3);
    expect_trig(2'd3, 2'd1, 8'd1);
    I_match = 8'h04; cyc(1); I_match = '0;
    check_st("t4_match_beats_expiry", 3, 1, 1);

    // Sync dropped in SEQ.
    I_arm = 1'b1; cyc(1); I_arm = 1'b0;
    I_match = 8'h02; cyc(1); I_match = '0;
    check_st("t4_seq", 2, 1, 1);
    I_synchronized = 1'b0; cyc(1); I_synchronized = 1'b1;
    check_st("t4_sync_drop", 1, 0, 1);

    // Saturation after 260 total expiries.
    repeat (254) begin
      I_match = 8'h02; cyc(1); I_match = '0;
      cyc(4);
    end
    check_st("t3_at_255", 1, 0, 255);
    repeat (5) begin
      I_match = 8'h02; cyc(1); I_match = '0;
      cyc(4);
    end
    check_st("t3_saturated", 1, 0, 255);

    // Disarm with the final match.
    I_num_steps = 2'd0; I_timeout = 16'd0;
    I_match = 8'h02; I_disarm = 1'b1; cyc(1); I_match = '0; I_disarm = 1'b0;
    check_st("t5_disarm", 0, 0, 255);
    check("t5_no_trigger", int'(O_trigger), 0);

    // Asynchronous reset mid-SEQ.
    I_num_steps = 2'd1;
    I_arm = 1'b1; cyc(1); I_arm = 1'b0;
    I_match = 8'h02; cyc(1); I_match = '0;
    check_st("t5_seq", 2, 1, 255);
    #2 reset_n = 1'b0;
    #1;
    check_st("t5_async_reset", 0, 0, 0);
    @(negedge trace_clk);
    reset_n = 1'b1;
    cyc(1);
    check_st("t5_after_reset", 0, 0, 0);

    // DONE persistence / auto-rearm.
    I_num_steps = 2'd0;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
    I_holdoff = 16'd5;
`endif
    I_arm = 1'b1; cyc(1); I_arm = 1'b0;
    expect_trig(2'd3, 2'd0, 8'd0);
    I_match = 8'h02; cyc(1); I_match = '0;
    check_st("t6_done", 3, 0, 0);
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
    cyc(5);
    check_st("t6_holdoff_wait", 3, 0, 0);
    cyc(1);
    check_st("t6_holdoff_rearm", 1, 0, 0);
`else
    held = 1'b1;
    repeat (100) begin
      cyc(1);
      if (O_state !== 2'd3) held = 1'b0;
    end
    check("t6_done_held_100", int'(held), 1);
`endif

    cyc(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_trig_seq.md
TRACE_TRIG_SEQ -- requirements
Module: trace_trig_seq

Interface
REQ-001 SHALL have parameter pMATCH_RULES, default 8: number of match-rule inputs.
REQ-002 SHALL have parameter pSTEPS, default 4: maximum sequence length.
REQ-003 SHALL have parameter pTIMER_WIDTH, default 16: width of the inter-step timeout timer.
REQ-004 SHALL have port trace_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port I_match, input, pMATCH_RULES: per-rule match pulses from the pattern matcher.
REQ-007 SHALL have port I_synchronized, input, 1: trace stream synchronized.
REQ-008 SHALL have port I_arm, input, 1: arm pulse.
REQ-009 SHALL have port I_disarm, input, 1: disarm pulse.
REQ-010 SHALL have port I_num_steps, input, 2: number of steps minus 1.
REQ-011 SHALL have port I_step_rules, input, pSTEPS*3: rule index per step; step k is bits [3k+2:3k].
REQ-012 SHALL have port I_timeout, input, pTIMER_WIDTH: window in cycles for steps 1..N; 0 means no timeout.
REQ-013 SHALL have port O_trigger, output, 1: one-cycle trigger pulse.
REQ-014 SHALL have port O_state, output, 2: state encoding IDLE=0, ARMED=1, SEQ=2, DONE=3.
REQ-015 SHALL have port O_step, output, 2: index of the step being awaited.
REQ-016 SHALL have port O_timeouts, output, 8: saturating count of expired sequences.

Function
REQ-017 SHALL implement four states: IDLE, ARMED, SEQ and DONE.
REQ-018 SHALL give I_disarm priority over all other events: any state goes to IDLE, step goes to 0, and the timer clears.
REQ-019 In IDLE, SHALL go to ARMED with step 0 on the edge after I_arm=1.
REQ-020 A step SHALL be satisfied in a cycle only when I_match[rule(step)]=1 and I_synchronized=1, and at most one step SHALL advance per cycle.
REQ-021 In ARMED, when step 0 is satisfied: if I_num_steps=0, go to DONE; otherwise go to SEQ with step 1 and the timer set to 0.
REQ-022 In SEQ, when step k is satisfied: if k=I_num_steps, go to DONE; otherwise step k+1 with the timer cleared.
REQ-023 In SEQ, the timer SHALL increment each cycle; if timer=I_timeout-1, I_timeout is not 0, and the step is not satisfied, go to ARMED with step 0 and O_timeouts incremented, saturating at 255.
REQ-024 If a match and expiry occur in the same cycle, the match SHALL win.
REQ-025 If I_synchronized=0 in SEQ, SHALL return to ARMED with step 0 and the timer cleared; O_timeouts SHALL be unchanged.
REQ-026 SHALL assert O_trigger, registered, for exactly one cycle, coincident with the first cycle of DONE, i.e. one cycle after the final match sample.
REQ-027 In DONE, O_step SHALL hold the final step, and I_arm SHALL rearm to ARMED with step 0.
REQ-028 I_arm in ARMED or SEQ SHALL be ignored.
REQ-029 I_num_steps, I_step_rules and I_timeout SHALL be sampled live, and changing them mid-sequence SHALL be legal; the I_num_steps comparison SHALL use the current value.
REQ-030 Rule index values of pMATCH_RULES or above SHALL never match.

Reset
REQ-031 While reset_n=0, state SHALL be IDLE, O_step=0, O_trigger=0, O_timeouts=0 and timer=0, asynchronously; exit from reset SHALL be synchronous to trace_clk.
REQ-032 Reset mid-sequence SHALL abort with no trigger pulse.

Configuration
REQ-033 The macro TRACE_TRIG_SEQ_AUTOREARM_EN SHALL control automatic rearm from DONE.
REQ-034 When defined, SHALL add input I_holdoff (pTIMER_WIDTH) and a holdoff counter; DONE SHALL return to ARMED with step 0 after I_holdoff+1 cycles in DONE; I_disarm keeps priority; I_arm in DONE rearms immediately.
REQ-035 When undefined, I_holdoff SHALL be absent, and DONE SHALL persist until I_arm, I_disarm or reset.

Verification
REQ-036 SHALL cover: single step, num_steps=0, rule 3; I_arm, then I_match=0x08 with sync=1 -> O_trigger one cycle later, O_state=3.
REQ-037 SHALL cover: three steps with rules 1,2,5 and timeout=10; matches 0x02, 0x04, 0x20 each 3 cycles apart -> exactly one trigger; O_step sequence 0,1,2.
REQ-038 SHALL cover: timeout=4; step 0 matches, no further match for 4 cycles -> ARMED, step 0, O_timeouts=1; after 260 expiries -> O_timeouts=255.
REQ-039 SHALL cover: the awaited match and timer expiry in the same cycle -> advance, O_timeouts unchanged; I_synchronized dropped in SEQ -> ARMED, no trigger.
REQ-040 SHALL cover: I_disarm and the final match in the same cycle -> IDLE, O_trigger=0; reset_n low mid-SEQ -> IDLE asynchronously.
REQ-041 SHALL cover: with the macro, holdoff=5 -> ARMED 6 cycles after trigger; without the macro -> DONE held for 100 cycles.
